simple_fetch_seq: RTL and testbench

Instruction-fetch and phase sequencer for the simple_isa core.
- Owns the PC and reads the instruction memory.
- Produces the INSTR and phase controls that the decode/execute block consumes.
- Consumes the decode/execute block's pc_incr at write-back to advance the PC.
- Replaces simulation-only illegal-opcode termination with a synthesizable sticky HALT state.

---
 rtl/simple_isa_pkg.sv | 51 +++++
 rtl/simple_fetch_seq_if.sv | 30 +++
 rtl/simple_fetch_seq.sv | 116 +++++++++++
 tb/tb_simple_fetch_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_isa_pkg.sv
// Shared definitions for the simple_isa core: opcodes, phase encoding,
// instruction field positions and the sequencer state type.
package simple_isa_pkg;

    typedef enum logic [3:0] {
        OP_MOV_RD  = 4'd0,
        OP_MOV_WR  = 4'd1,
        OP_MOV_IND = 4'd2,
        OP_MOV_IMM = 4'd3,
        OP_ADD     = 4'd4,
        OP_SUB     = 4'd5,
        OP_JZ      = 4'd8,
        OP_JNZ     = 4'd9
    } opcode_e;

    localparam logic [1:0] PHASE_IF = 2'd0;
    localparam logic [1:0] PHASE_ID = 2'd1;
    localparam logic [1:0] PHASE_EX = 2'd2;
    localparam logic [1:0] PHASE_WB = 2'd3;

    // Direct forms carry a 4-bit and an 8-bit operand; register forms two nibbles.
    localparam int OPCODE_HI     = 15;
    localparam int OPCODE_LO     = 12;
    localparam int OP1_DIRECT_HI = 11;
    localparam int OP1_DIRECT_LO = 8;
    localparam int OP2_DIRECT_HI = 7;
    localparam int OP2_DIRECT_LO = 0;
    localparam int OP1_HI        = 7;
    localparam int OP1_LO        = 4;
    localparam int OP2_HI        = 3;
    localparam int OP2_LO        = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_REQ,
        ST_IF_CAP,
        ST_ID,
        ST_EX,
        ST_WB,
        ST_HALT
    } seq_state_e;

    function automatic logic is_legal_opcode(input logic [3:0] op);
        case (op)
            OP_MOV_RD, OP_MOV_WR, OP_MOV_IND, OP_MOV_IMM,
            OP_ADD, OP_SUB, OP_JZ, OP_JNZ: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/simple_fetch_seq_if.sv
// Signal bundle between the fetch sequencer (master) and its environment:
// run/stall controls, instruction memory port and sequencer status.
interface simple_fetch_seq_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               run;
    logic               stall;
    logic [PC_W-1:0]    pc_incr;
    logic               imem_rd;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_dout;
    logic [INSTR_W-1:0] INSTR;
    logic [1:0]         phase;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               halted;
    logic               illegal;
    logic [15:0]        retired_cnt;

    modport master (
        input  run, stall, pc_incr, imem_dout,
        output imem_rd, imem_addr, INSTR, phase, pc, busy, halted, illegal, retired_cnt
    );

    modport slave (
        output run, stall, pc_incr, imem_dout,
        input  imem_rd, imem_addr, INSTR, phase, pc, busy, halted, illegal, retired_cnt
    );
endinterface

// File: rtl/simple_fetch_seq.sv
// Instruction-fetch and phase sequencer: owns the PC, fetches from imem,
// steps ID/EX/WB for decode/execute and parks in a sticky HALT on bad opcodes.
module simple_fetch_seq
    import simple_isa_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    simple_fetch_seq_if.master bus
);

    seq_state_e         state;
    seq_state_e         state_next;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    imem_addr_q;
    logic               imem_rd_q;
    logic [INSTR_W-1:0] instr_q;
    logic               illegal_q;
    logic [15:0]        retired_q;
    logic [1:0]         phase;
    logic               fetch_ok;
    logic               wb_exit;

    assign fetch_ok = is_legal_opcode(bus.imem_dout[OPCODE_HI:OPCODE_LO]);
    assign wb_exit  = (state == ST_WB) && !bus.stall;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        phase      = PHASE_IF;
        case (state)
            ST_IDLE: begin
                if (bus.run) state_next = ST_IF_REQ;
            end
            ST_IF_REQ: begin
                state_next = ST_IF_CAP;
            end
            ST_IF_CAP: begin
                state_next = fetch_ok ? ST_ID : ST_HALT;
            end
            ST_ID: begin
                phase = PHASE_ID;
                if (!bus.stall) state_next = ST_EX;
            end
            ST_EX: begin
                phase = PHASE_EX;
                if (!bus.stall) state_next = ST_WB;
            end
            ST_WB: begin
                phase = PHASE_WB;
                if (!bus.stall) begin
                    // Modular add: negative deltas arrive in two's complement.
                    pc_next    = pc_q + bus.pc_incr;
                    state_next = bus.run ? ST_IF_REQ : ST_IDLE;
                end
            end
            ST_HALT: begin
                phase = PHASE_WB;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_rd_q   <= 1'b0;
            instr_q     <= '0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            imem_rd_q <= (state_next == ST_IF_REQ);
            // The address register only moves on a new request, so it holds
            // the last fetched address while the strobe is low.
            if (state_next == ST_IF_REQ) imem_addr_q <= pc_next;
            if (state == ST_IF_CAP) begin
                instr_q <= bus.imem_dout;
                if (!fetch_ok) illegal_q <= 1'b1;
            end
            if (wb_exit) retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.imem_rd     = imem_rd_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.INSTR       = instr_q;
    assign bus.phase       = phase;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state != ST_IDLE) && (state != ST_HALT);
    assign bus.halted      = (state == ST_HALT);
    assign bus.illegal     = illegal_q;
    assign bus.retired_cnt = retired_q;

    // Decode/execute relies on INSTR not moving while it works on it.
    a_instr_stable: assert property (@(posedge clk) disable iff (reset)
        (state inside {ST_ID, ST_EX, ST_WB}) && (state_next != ST_IF_REQ) && (state_next != ST_IDLE)
        |=> $stable(instr_q));

    a_halt_sticky: assert property (@(posedge clk) disable iff (reset)
        (state == ST_HALT) |=> (state == ST_HALT));

endmodule

// File: tb/tb_simple_fetch_seq.sv
// Self-checking bench for simple_fetch_seq: directed vector table, random
// instruction stream against an instruction-level model, halt and async reset.
module tb_simple_fetch_seq;

    logic clk;
    logic reset;

    simple_fetch_seq_if #(.PC_W(8), .INSTR_W(16)) bus ();

    simple_fetch_seq #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cur_instr = 0;
    int cur_cyc   = 0;

    logic [15:0] mem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    logic [7:0]  last_fetch;

    logic [3:0] legal_ops   [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9};
    logic [3:0] illegal_ops [8] = '{4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    // Memory responder: data appears one cycle after the strobe cycle; any
    // other cycle returns a poison word with an illegal opcode.
    logic       rd_prev   = 1'b0;
    logic [7:0] addr_prev = 8'h00;
    always @(negedge clk) begin
        bus.imem_dout = rd_prev ? mem[addr_prev] : 16'hF0F0;
        rd_prev       = bus.imem_rd;
        addr_prev     = bus.imem_addr;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (instr %0d cycle %0d): got 0x%0h expected 0x%0h",
                     name, cur_instr, cur_cyc, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst INSTR",       32'(bus.INSTR), 32'h0);
        check("rst phase",       32'(bus.phase), 32'h0);
        check("rst imem_rd",     32'(bus.imem_rd), 32'h0);
        check("rst imem_addr",   32'(bus.imem_addr), 32'h0);
        check("rst pc",          32'(bus.pc), 32'h0);
        check("rst busy",        32'(bus.busy), 32'h0);
        check("rst halted",      32'(bus.halted), 32'h0);
        check("rst illegal",     32'(bus.illegal), 32'h0);
        check("rst retired_cnt", 32'(bus.retired_cnt), 32'h0);
    endtask

    // Plays one legal instruction starting at the negedge of its IF_REQ cycle.
    // Expected phases come from the stall plan: 2 fetch cycles, then each of
    // ID/EX/WB lasts 1 + its stall count.
    task automatic do_instr(input logic [15:0] word, input logic [7:0] incr,
                            input int s_id, input int s_ex, input int s_wb,
                            input bit run_mid, input bit run_wb);
        int         total;
        logic [1:0] exp_ph [$];
        bit         plan   [$];
        total = 5 + s_id + s_ex + s_wb;
        for (int i = 0; i < 2; i++) begin
            exp_ph.push_back(2'd0);
            plan.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i <= s_id; i++) begin exp_ph.push_back(2'd1); plan.push_back(i < s_id); end
        for (int i = 0; i <= s_ex; i++) begin exp_ph.push_back(2'd2); plan.push_back(i < s_ex); end
        for (int i = 0; i <= s_wb; i++) begin exp_ph.push_back(2'd3); plan.push_back(i < s_wb); end
        mem[m_pc] = word;
        for (int k = 0; k < total; k++) begin
            cur_cyc = k;
            check("phase",       32'(bus.phase), 32'(exp_ph[k]));
            check("imem_rd",     32'(bus.imem_rd), 32'(k == 0));
            check("imem_addr",   32'(bus.imem_addr), 32'(m_pc));
            check("busy",        32'(bus.busy), 32'h1);
            check("halted",      32'(bus.halted), 32'h0);
            check("pc",          32'(bus.pc), 32'(m_pc));
            check("retired_cnt", 32'(bus.retired_cnt), 32'(m_ret));
            if (k >= 2) check("INSTR", 32'(bus.INSTR), 32'(word));
            bus.stall   = plan[k];
            bus.run     = (k == total - 1) ? run_wb : run_mid;
            bus.pc_incr = (k == total - 1) ? incr : 8'($urandom);
            @(negedge clk);
        end
        last_fetch = m_pc;
        m_pc       = m_pc + incr;
        m_ret      = m_ret + 16'd1;
        cur_cyc    = total;
        check("pc after wb",      32'(bus.pc), 32'(m_pc));
        check("retired after wb", 32'(bus.retired_cnt), 32'(m_ret));
        check("busy after wb",    32'(bus.busy), 32'(run_wb));
        check("imem_rd after wb", 32'(bus.imem_rd), 32'(run_wb));
        check("phase after wb",   32'(bus.phase), 32'h0);
        cur_instr++;
    endtask

    // Sits in IDLE for n cycles (run raised in the last one), ending at the
    // negedge of the next IF_REQ cycle.
    task automatic idle_then_restart(input int n);
        for (int i = 0; i < n; i++) begin
            cur_cyc = -1;
            check("idle phase",     32'(bus.phase), 32'h0);
            check("idle busy",      32'(bus.busy), 32'h0);
            check("idle imem_rd",   32'(bus.imem_rd), 32'h0);
            check("idle imem_addr", 32'(bus.imem_addr), 32'(last_fetch));
            check("idle pc",        32'(bus.pc), 32'(m_pc));
            bus.stall = 1'($urandom_range(0, 1));
            bus.run   = (i == n - 1);
            @(negedge clk);
        end
        check("restart imem_rd",   32'(bus.imem_rd), 32'h1);
        check("restart imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    endtask

    // Fetches an illegal word from the IF_REQ negedge and checks the sticky HALT.
    task automatic do_halt(input logic [15:0] word);
        mem[m_pc] = word;
        check("halt req imem_rd", 32'(bus.imem_rd), 32'h1);
        check("halt req addr",    32'(bus.imem_addr), 32'(m_pc));
        @(negedge clk);
        check("halt cap busy",    32'(bus.busy), 32'h1);
        check("halt cap halted",  32'(bus.halted), 32'h0);
        bus.run = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cur_cyc = 100 + i;
            check("halted",       32'(bus.halted), 32'h1);
            check("illegal",      32'(bus.illegal), 32'h1);
            check("halt busy",    32'(bus.busy), 32'h0);
            check("halt phase",   32'(bus.phase), 32'h3);
            check("halt INSTR",   32'(bus.INSTR), 32'(word));
            check("halt pc",      32'(bus.pc), 32'(m_pc));
            check("halt retired", 32'(bus.retired_cnt), 32'(m_ret));
            check("halt imem_rd", 32'(bus.imem_rd), 32'h0);
            bus.run   = ~bus.run;
            bus.stall = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        cur_cyc = -2;
        check_reset_values();
        reset = 1'b0;
        m_pc       = 8'h00;
        m_ret      = 16'h0;
        last_fetch = 8'h00;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [7:0]  incr;
        int          s_id;
        int          s_ex;
        int          s_wb;
        bit          run_mid;
        bit          run_wb;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'h3A55, 8'h01, 0, 0, 0, 1'b1, 1'b1, 8'h01};
        vecs[1] = '{16'h4012, 8'h0F, 0, 3, 0, 1'b1, 1'b1, 8'h10};
        vecs[2] = '{16'h8000, 8'hFC, 0, 0, 0, 1'b1, 1'b1, 8'h0C};
        vecs[3] = '{16'h5123, 8'hF3, 1, 0, 2, 1'b1, 1'b1, 8'hFF};
        vecs[4] = '{16'h9001, 8'h01, 0, 0, 0, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{16'h0111, 8'h02, 2, 1, 0, 1'b1, 1'b1, 8'h02};
        vecs[6] = '{16'h1222, 8'hFE, 0, 0, 1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{16'h2333, 8'h05, 0, 2, 0, 1'b0, 1'b1, 8'h05};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        bus.run     = 1'b0;
        bus.stall   = 1'b0;
        bus.pc_incr = 8'h00;
        reset       = 1'b1;
        @(negedge clk);
        apply_reset();

        // IDLE cycle with run raised, then the directed table.
        bus.run = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 8; v++) begin
            do_instr(vecs[v].word, vecs[v].incr, vecs[v].s_id, vecs[v].s_ex, vecs[v].s_wb,
                     vecs[v].run_mid, vecs[v].run_wb);
            check("table pc", 32'(bus.pc), 32'(vecs[v].exp_pc));
            if (!vecs[v].run_wb) idle_then_restart(2);
        end

        // Illegal opcode at 0x05, then recovery only through reset.
        do_halt(16'h6000);
        apply_reset();
        bus.run = 1'b1;
        @(negedge clk);

        // Random legal stream against the instruction-level model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [15:0] word;
            bit          run_wb;
            op     = legal_ops[$urandom_range(0, 7)];
            word   = {op, 12'($urandom)};
            run_wb = ($urandom_range(0, 4) != 0);
            do_instr(word, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), run_wb);
            if (!run_wb) idle_then_restart($urandom_range(1, 3));
        end

        // Asynchronous reset between edges while the instruction sits in EX.
        mem[m_pc] = 16'h4012;
        bus.stall = 1'b0;
        bus.run   = 1'b1;
        repeat (3) @(negedge clk);
        cur_cyc = -3;
        check("pre-reset phase", 32'(bus.phase), 32'h2);
        bus.stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        reset      = 1'b0;
        bus.run    = 1'b0;
        m_pc       = 8'h00;
        m_ret      = 16'h0;
        last_fetch = 8'h00;
        idle_then_restart(2);

        // A randomly chosen illegal opcode at address 0 halts as well.
        do_halt({illegal_ops[$urandom_range(0, 7)], 12'($urandom)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
